// File: rtl/booth_mult_r4.sv
// Radix-4 Booth sequential multiplier, parametrised width.
// Signed/unsigned operands, valid/ready handshake on both sides.
module booth_mult_r4 #(
    parameter int WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic               busy
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int EW   = WIDTH + 2;
    localparam int HW   = WIDTH + 3;
    localparam int AW   = HW + EW;
    localparam int CW   = $clog2(ITER + 1);

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_mult_r4: WIDTH must be even and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic                lost_q, lost_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [EW-1:0]       mcand_q, mcand_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;

    logic [EW-1:0]       mcand_ext;
    logic [EW-1:0]       mplier_ext;
    logic [HW-1:0]       a_hw;
    logic [HW-1:0]       a2_hw;
    logic [HW-1:0]       addend;
    logic [HW-1:0]       hi_sum;
    logic [AW-1:0]       step_acc;

    // Extend the incoming operands by two bits so the top Booth digit
    // sees the true sign (or a zero for unsigned operands).
    always_comb begin
        if (signed_mode) begin
            mcand_ext  = {{2{multiplicand[WIDTH-1]}}, multiplicand};
            mplier_ext = {{2{multiplier[WIDTH-1]}}, multiplier};
        end else begin
            mcand_ext  = {2'b00, multiplicand};
            mplier_ext = {2'b00, multiplier};
        end
    end

    assign a_hw  = {mcand_q[EW-1], mcand_q};
    assign a2_hw = {mcand_q, 1'b0};

    // Booth digit select from the two low accumulator bits and the lost bit.
    always_comb begin
        addend = '0;
        unique case ({acc_q[1:0], lost_q})
            3'b001, 3'b010: addend = a_hw;
            3'b011:         addend = a2_hw;
            3'b100:         addend = -a2_hw;
            3'b101, 3'b110: addend = -a_hw;
            default:        addend = '0;
        endcase
    end

    assign hi_sum   = acc_q[AW-1 -: HW] + addend;
    assign step_acc = AW'($signed({hi_sum, acc_q[EW-1:0]}) >>> 2);

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        lost_d  = lost_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = {{HW{1'b0}}, mplier_ext};
                    lost_d  = 1'b0;
                    cnt_d   = CW'(ITER);
                    mcand_d = mcand_ext;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = step_acc;
                lost_d = acc_q[1];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    prod_d  = step_acc[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            lost_q  <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            lost_q  <= lost_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign prod      = prod_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Directed and randomised checks of booth_mult_r4 at WIDTH 12 and 16.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_booth_mult_r4;

    logic clk;
    logic rst_n;

    logic        st12, ir12, sm12, ov12, or12, bz12;
    logic [11:0] a12, b12;
    logic [23:0] p12;

    logic        st16, ir16, sm16, ov16, or16, bz16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int n_chk;
    int n_fail;

    booth_mult_r4 #(.WIDTH(12)) u_dut12 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (st12),
        .in_ready     (ir12),
        .signed_mode  (sm12),
        .multiplicand (a12),
        .multiplier   (b12),
        .out_valid    (ov12),
        .out_ready    (or12),
        .prod         (p12),
        .busy         (bz12)
    );

    booth_mult_r4 #(.WIDTH(16)) u_dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (st16),
        .in_ready     (ir16),
        .signed_mode  (sm16),
        .multiplicand (a16),
        .multiplier   (b16),
        .out_valid    (ov16),
        .out_ready    (or16),
        .prod         (p16),
        .busy         (bz16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one 12-bit operation, wait for out_valid, check latency/product.
    task automatic go12(input string tag, input logic sm,
                        input logic [11:0] a, input logic [11:0] b,
                        input logic [23:0] exp);
        int k;
        sm12 = sm;
        a12  = a;
        b12  = b;
        st12 = 1'b1;
        @(negedge clk);
        st12 = 1'b0;
        a12  = ~a;
        b12  = ~b;
        sm12 = ~sm;
        check({tag, "_busy"}, {ir12, bz12}, 2'b01);
        k = 1;
        while (!ov12 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'd8);
        check({tag, "_prod"}, 64'(p12), 64'(exp));
    endtask

    task automatic rel12(input string tag);
        or12 = 1'b1;
        @(negedge clk);
        or12 = 1'b0;
        check({tag, "_idle"}, {ov12, ir12, bz12}, 3'b010);
    endtask

    // 16-bit operation with a consumer stall of 'stall' cycles.
    task automatic go16(input string tag, input logic sm,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int stall);
        int k;
        sm16 = sm;
        a16  = a;
        b16  = b;
        st16 = 1'b1;
        @(negedge clk);
        st16 = 1'b0;
        a16  = 16'h0;
        b16  = 16'h0;
        k = 1;
        while (!ov16 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 64'(k), 64'd10);
        check({tag, "_prod"}, 64'(p16), 64'(exp));
        repeat (stall) @(negedge clk);
        check({tag, "_hold"}, 64'({ov16, p16}), 64'({1'b1, exp}));
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        check({tag, "_idle"}, {ov16, ir16, bz16}, 3'b010);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0]        held;
        int                 seen;
        logic [15:0]        ra;
        logic [15:0]        rb;
        logic               rs;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        re;
        n_chk  = 0;
        n_fail = 0;
        clk    = 1'b0;
        rst_n  = 1'b0;
        {st12, sm12, or12, a12, b12} = '0;
        {st16, sm16, or16, a16, b16} = '0;
        repeat (2) @(negedge clk);
        check("rst12", {ir12, ov12, bz12, p12}, {3'b100, 24'h0});
        check("rst16", {ir16, ov16, bz16, p16}, {3'b100, 32'h0});
        rst_n = 1'b1;
        @(negedge clk);

        or12 = 1'b1;
        @(negedge clk);
        or12 = 1'b0;
        check("ordy_idle", {ir12, ov12, bz12}, 3'b100);

        go12("s3xm5", 1'b1, 12'd3, 12'hFFB, 24'hFFFFF1);
        rel12("s3xm5");
        go12("smin2", 1'b1, 12'h800, 12'h800, 24'h400000);
        rel12("smin2");
        go12("sminmax", 1'b1, 12'h800, 12'h7FF, 24'hC00800);
        rel12("sminmax");
        go12("umax", 1'b0, 12'hFFF, 12'hFFF, 24'hFFE001);
        rel12("umax");
        go12("sm1", 1'b1, 12'hFFF, 12'hFFF, 24'h000001);
        rel12("sm1");

        go12("bp", 1'b0, 12'd100, 12'd200, 24'd20000);
        held = p12;
        for (int i = 0; i < 5; i++) begin
            st12 = 1'b1;
            sm12 = 1'b1;
            a12  = 12'(i + 5);
            b12  = 12'hFFD;
            @(negedge clk);
            st12 = 1'b0;
            check("bp_hold", {ov12, ir12, bz12, p12}, {3'b101, held});
        end
        rel12("bp");
        check("bp_prod", 64'(p12), 64'd20000);
        @(negedge clk);
        check("bp_ign", {ir12, bz12}, 2'b10);

        sm12 = 1'b0;
        a12  = 12'd5;
        b12  = 12'd5;
        st12 = 1'b1;
        @(negedge clk);
        st12 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid", {ir12, ov12, bz12, p12}, {3'b100, 24'h0});
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov12 || bz12) seen++;
        end
        check("rst_stale", 64'(seen), 64'd0);
        go12("r7x9", 1'b0, 12'd7, 12'd9, 24'h00003F);
        rel12("r7x9");

        go16("u16max", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
        go16("s16min", 1'b1, 16'h8000, 16'h8000, 32'h40000000, 2);

        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (rs) begin
                sa = {{16{ra[15]}}, ra};
                sb = {{16{rb[15]}}, rb};
                re = 32'(sa * sb);
            end else begin
                re = {16'h0, ra} * {16'h0, rb};
            end
            go16("rnd", rs, ra, rb, re, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
